video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Pixel-clock-domain video timing generator fed by the TMDS PLL's divided output (74.25 MHz) and its lock flag.
- Qualifies PLL lock, then produces DE/HSYNC/VSYNC plus active-pixel coordinates for the pattern/camera source and the TMDS encoder.
- Default geometry is 1280x720p60 (CEA-861).
- Timing is forced idle whenever lock is absent or lost.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (pixels)
H_SYNC, 40, hsync width (pixels)
H_BP, 220, horizontal back porch (pixels)
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 20, vertical back porch (lines)
HS_POL, 1, hsync active level (1 = active high)
VS_POL, 1, vsync active level
LOCK_WAIT, 1024, consecutive synchronized-lock cycles required before running (>=1)

Ports:
I_pxl_clk  in  1  pixel clock (PLL divided output)
I_rst_n  in  1  synchronous active-low reset
I_pll_lock  in  1  PLL lock, asynchronous to I_pxl_clk
O_de  out  1  data enable, high during active pixels
O_hs  out  1  horizontal sync, polarity per HS_POL
O_vs  out  1  vertical sync, polarity per VS_POL
O_x  out  12  active pixel column; 0 when O_de low
O_y  out  12  active line; 0 when O_de low
O_frame_start  out  1  one-cycle pulse coincident with pixel (0,0)
O_running  out  1  high while state is RUN

Behaviour:
- Reset: I_rst_n sampled on the rising edge of I_pxl_clk; reset overrides all else.
- Reset values:
  - state = WAIT_LOCK; h_cnt = v_cnt = 0; lock synchronizer = 0; settle counter = 0.
  - O_de = 0, O_hs = ~HS_POL, O_vs = ~VS_POL, O_x = O_y = 0, O_frame_start = 0, O_running = 0.
- Lock sync: I_pll_lock passes a 2-flop synchronizer; lock_s is the second flop. All lock decisions use lock_s.
- State machine:
  - WAIT_LOCK: settle counter cleared; lock_s = 1 -> SETTLE.
  - SETTLE: settle counter increments each cycle lock_s = 1.
    - lock_s = 0 -> WAIT_LOCK, counter cleared.
    - When the counter reaches LOCK_WAIT-1 with lock_s = 1 -> RUN.
    - RUN is entered after exactly LOCK_WAIT consecutive lock_s-high cycles.
  - RUN: counters advance.
    - lock_s = 0 -> WAIT_LOCK on the next edge; h_cnt and v_cnt are cleared.
    - A subsequent relock starts at pixel (0,0) after a full LOCK_WAIT settle.
- Counters (RUN only; held at 0 otherwise):
  - H_TOTAL = sum of H_*; V_TOTAL = sum of V_*.
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments only when h_cnt wraps; it wraps V_TOTAL-1 -> 0 at the same edge.
  - Widths are 12 bits; H_TOTAL and V_TOTAL must be <= 4096.
- Per-line order: active, front porch, sync, back porch (same order vertically).
- Decode, combinational from current counters:
  - de = RUN & h_cnt < H_ACTIVE & v_cnt < V_ACTIVE.
  - hs_act = RUN & H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_act = RUN & V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. vsync edges align to h_cnt = 0.
  - frame_start = RUN & h_cnt = 0 & v_cnt = 0.
- Registered outputs (latency 1 cycle from the counter state):
  - O_de = de; O_hs = hs_act ? HS_POL : ~HS_POL; O_vs likewise with VS_POL.
  - O_x = de ? h_cnt : 0; O_y = de ? v_cnt : 0.
  - O_frame_start = frame_start; O_running = (state == RUN).
- First RUN cycle has counters at (0,0). The next edge shows O_de = 1, O_x = 0, O_y = 0, O_frame_start = 1, O_running = 1.
- Lock loss mid-frame: the cycle after state leaves RUN, all outputs take their reset values. No partial line completion.
- Lock glitch shorter than 1 cycle may be missed by the synchronizer; this is acceptable.
- Lock asserted at reset release: WAIT_LOCK still requires the synchronizer delay (2 cycles) plus LOCK_WAIT cycles.

Test Plan:
Small geometry for all cases: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), LOCK_WAIT = 4, polarities 1.
1. Reset held 5 cycles with lock = 1 -> all outputs at reset values. After release and lock steady: O_running rises exactly 2+4+1 edges later; O_frame_start pulses on that same edge with O_x = O_y = 0.
2. Steady run for 3 frames -> per line, O_de high 8 consecutive cycles (O_x 0..7) for lines 0..3. O_hs high at cycles 10..12 of each 16-cycle line. O_vs high for lines 5..6 (32 cycles). O_frame_start period = 128 cycles.
3. Lock drops for 2 cycles during SETTLE (count = 2) -> settle restarts. RUN only after 4 fresh consecutive lock_s cycles.
4. Lock drops at line 2 pixel 5 -> O_de/O_running low within 3+1 edges; O_hs/O_vs inactive. On relock, the first frame starts at (0,0) with a frame_start pulse.
5. HS_POL = 0, VS_POL = 0 -> idle levels 1, sync pulses low at the same positions as scenario 2.
6. Synchronous reset asserted mid-active-line in RUN -> next edge shows all reset values; counters at 0; state WAIT_LOCK.

Source files
------------

// File: rtl/video_timing_gen.sv
// Pixel-clock video timing: qualifies PLL lock, then emits DE/HS/VS, active coordinates and frame start.
// Outputs are registered one cycle behind the counters; no backpressure, timing idles while lock is absent.
module video_timing_gen #(
   parameter int H_ACTIVE  = 1280,
   parameter int H_FP      = 110,
   parameter int H_SYNC    = 40,
   parameter int H_BP      = 220,
   parameter int V_ACTIVE  = 720,
   parameter int V_FP      = 5,
   parameter int V_SYNC    = 5,
   parameter int V_BP      = 20,
   parameter bit HS_POL    = 1'b1,
   parameter bit VS_POL    = 1'b1,
   parameter int LOCK_WAIT = 1024
) (
   input  logic        I_pxl_clk,
   input  logic        I_rst_n,
   input  logic        I_pll_lock,
   output logic        O_de,
   output logic        O_hs,
   output logic        O_vs,
   output logic [11:0] O_x,
   output logic [11:0] O_y,
   output logic        O_frame_start,
   output logic        O_running
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int SW      = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT + 1) : 1;

   localparam logic [11:0] H_ACT_L   = 12'(H_ACTIVE);
   localparam logic [11:0] H_SS_L    = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_SE_L    = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_LAST_L  = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_ACT_L   = 12'(V_ACTIVE);
   localparam logic [11:0] V_SS_L    = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_SE_L    = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_LAST_L  = 12'(V_TOTAL - 1);
   localparam logic [SW-1:0] LW_LAST = SW'(LOCK_WAIT - 1);
   localparam logic [SW-1:0] LW_ONE  = SW'(1);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_SETTLE    = 2'd1,
      ST_RUN       = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_lock_meta;
   logic          r_lock_s;
   logic [SW-1:0] r_settle;
   logic [SW-1:0] w_settle_nxt;
   logic [11:0]   r_h_cnt;
   logic [11:0]   r_v_cnt;
   logic [11:0]   w_h_nxt;
   logic [11:0]   w_v_nxt;
   logic          w_run;
   logic          w_de;
   logic          w_hs_act;
   logic          w_vs_act;
   logic          w_frame_start;

   always_ff @(posedge I_pxl_clk) begin
      if (!I_rst_n) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
      end else begin
         r_lock_meta <= I_pll_lock;
         r_lock_s    <= r_lock_meta;
      end
   end

   always_ff @(posedge I_pxl_clk) begin
      if (!I_rst_n) begin
         r_state  <= ST_WAIT_LOCK;
         r_settle <= '0;
         r_h_cnt  <= '0;
         r_v_cnt  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_settle <= w_settle_nxt;
         r_h_cnt  <= w_h_nxt;
         r_v_cnt  <= w_v_nxt;
      end
   end

   // The WAIT_LOCK cycle that first sees lock_s counts as the first of LOCK_WAIT.
   always_comb begin
      w_state_nxt  = r_state;
      w_settle_nxt = '0;
      case (r_state)
         ST_WAIT_LOCK: begin
            if (r_lock_s) begin
               if (LOCK_WAIT <= 1) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt  = ST_SETTLE;
                  w_settle_nxt = LW_ONE;
               end
            end
         end
         ST_SETTLE: begin
            if (!r_lock_s) begin
               w_state_nxt = ST_WAIT_LOCK;
            end else if (r_settle == LW_LAST) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_settle_nxt = r_settle + LW_ONE;
            end
         end
         ST_RUN: begin
            if (!r_lock_s) begin
               w_state_nxt = ST_WAIT_LOCK;
            end
         end
         default: w_state_nxt = ST_WAIT_LOCK;
      endcase
   end

   assign w_run = (r_state == ST_RUN);

   // Counters advance only while RUN persists; any exit drops them straight back to (0,0).
   always_comb begin
      w_h_nxt = '0;
      w_v_nxt = '0;
      if (w_run && r_lock_s) begin
         if (r_h_cnt == H_LAST_L) begin
            w_h_nxt = '0;
            w_v_nxt = (r_v_cnt == V_LAST_L) ? 12'd0 : r_v_cnt + 12'd1;
         end else begin
            w_h_nxt = r_h_cnt + 12'd1;
            w_v_nxt = r_v_cnt;
         end
      end
   end

   assign w_de          = w_run && (r_h_cnt < H_ACT_L) && (r_v_cnt < V_ACT_L);
   assign w_hs_act      = w_run && (r_h_cnt >= H_SS_L) && (r_h_cnt < H_SE_L);
   assign w_vs_act      = w_run && (r_v_cnt >= V_SS_L) && (r_v_cnt < V_SE_L);
   assign w_frame_start = w_run && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);

   always_ff @(posedge I_pxl_clk) begin
      if (!I_rst_n) begin
         O_de          <= 1'b0;
         O_hs          <= ~HS_POL;
         O_vs          <= ~VS_POL;
         O_x           <= '0;
         O_y           <= '0;
         O_frame_start <= 1'b0;
         O_running     <= 1'b0;
      end else begin
         O_de          <= w_de;
         O_hs          <= w_hs_act ? HS_POL : ~HS_POL;
         O_vs          <= w_vs_act ? VS_POL : ~VS_POL;
         O_x           <= w_de ? r_h_cnt : 12'd0;
         O_y           <= w_de ? r_v_cnt : 12'd0;
         O_frame_start <= w_frame_start;
         O_running     <= w_run;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 16x8 geometry, one active-high and one active-low sync instance.
module tb_video_timing_gen;

   logic        clk;
   logic        rst_n;
   logic        lock;

   logic        de0, hs0, vs0, fs0, run0;
   logic [11:0] x0, y0;
   logic        de1, hs1, vs1, fs1, run1;
   logic [11:0] x1, y1;

   int n_checks = 0;
   int n_fail   = 0;

   video_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_WAIT(4)
   ) u_dut_p (
      .I_pxl_clk(clk), .I_rst_n(rst_n), .I_pll_lock(lock),
      .O_de(de0), .O_hs(hs0), .O_vs(vs0), .O_x(x0), .O_y(y0),
      .O_frame_start(fs0), .O_running(run0)
   );

   video_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_WAIT(4)
   ) u_dut_n (
      .I_pxl_clk(clk), .I_rst_n(rst_n), .I_pll_lock(lock),
      .O_de(de1), .O_hs(hs1), .O_vs(vs1), .O_x(x1), .O_y(y1),
      .O_frame_start(fs1), .O_running(run1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_de"}, 32'(de0), 32'd0);
      check({tag, "_hs_p"}, 32'(hs0), 32'd0);
      check({tag, "_vs_p"}, 32'(vs0), 32'd0);
      check({tag, "_x"}, 32'(x0), 32'd0);
      check({tag, "_y"}, 32'(y0), 32'd0);
      check({tag, "_fs"}, 32'(fs0), 32'd0);
      check({tag, "_run"}, 32'(run0), 32'd0);
      check({tag, "_hs_n"}, 32'(hs1), 32'd1);
      check({tag, "_vs_n"}, 32'(vs1), 32'd1);
      check({tag, "_run_n"}, 32'(run1), 32'd0);
   endtask

   // Expected outputs k cycles after the first frame_start edge: line 16 px, frame 8 lines.
   task automatic check_pos(input int k);
      int  hc, vc;
      bit  de, hs, vs;
      hc = k % 16;
      vc = (k / 16) % 8;
      de = (hc < 8) && (vc < 4);
      hs = (hc >= 10) && (hc <= 12);
      vs = (vc >= 5) && (vc <= 6);
      check("pos_de", 32'(de0), 32'(de));
      check("pos_x", 32'(x0), de ? 32'(hc) : 32'd0);
      check("pos_y", 32'(y0), de ? 32'(vc) : 32'd0);
      check("pos_hs_p", 32'(hs0), 32'(hs));
      check("pos_vs_p", 32'(vs0), 32'(vs));
      check("pos_fs", 32'(fs0), 32'((k % 128) == 0));
      check("pos_run", 32'(run0), 32'd1);
      check("pos_hs_n", 32'(hs1), 32'(!hs));
      check("pos_vs_n", 32'(vs1), 32'(!vs));
      check("pos_de_n", 32'(de1), 32'(de));
   endtask

   // From a negedge with lock steady high: release reset, expect RUN visible on edge 7.
   task automatic release_and_start(input string tag);
      rst_n = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         check({tag, "_run_early"}, 32'(run0), 32'd0);
      end
      step();
      check({tag, "_run"}, 32'(run0), 32'd1);
      check({tag, "_fs"}, 32'(fs0), 32'd1);
      check({tag, "_de"}, 32'(de0), 32'd1);
      check({tag, "_x"}, 32'(x0), 32'd0);
      check({tag, "_y"}, 32'(y0), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      lock  = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_idle("rst");

      release_and_start("start");

      // Three full frames, then on into frame 3 up to line 2 pixel 5.
      for (int k = 0; k < 421; k++) begin
         check_pos(k);
         step();
      end
      check_pos(421);

      lock = 1'b0;
      repeat (3) step();
      check("drop_run_hold", 32'(run0), 32'd1);
      step();
      check_idle("drop");

      // Relock with a two-cycle dropout once the settle count has reached 2.
      lock = 1'b1;
      step();
      check("settle_run_a1", 32'(run0), 32'd0);
      step();
      check("settle_run_a2", 32'(run0), 32'd0);
      lock = 1'b0;
      step();
      check("settle_run_a3", 32'(run0), 32'd0);
      step();
      check("settle_run_a4", 32'(run0), 32'd0);
      lock = 1'b1;
      for (int i = 5; i <= 10; i++) begin
         step();
         check("settle_run_late", 32'(run0), 32'd0);
      end
      step();
      check("relock_run", 32'(run0), 32'd1);
      check("relock_fs", 32'(fs0), 32'd1);
      check("relock_x", 32'(x0), 32'd0);
      check("relock_y", 32'(y0), 32'd0);
      for (int k = 0; k < 4; k++) begin
         check_pos(k);
         step();
      end
      check_pos(4);

      // Synchronous reset mid active line.
      rst_n = 1'b0;
      step();
      check_idle("mid_rst");
      step();
      check_idle("mid_rst_hold");
      release_and_start("restart");
      for (int k = 0; k < 20; k++) begin
         check_pos(k);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
